// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control bundle: bit positions, default widths
// and the bubble value used when a stage must carry no instruction.
package ctrl_pkg;

    localparam int NB_CTRL_DEF = 9;
    localparam int NB_REG_DEF  = 5;
    localparam int NB_CNT_DEF  = 32;

    localparam int CTRL_ALUSRC   = 8;
    localparam int CTRL_MEM2REG  = 7;
    localparam int CTRL_REGWR    = 6;
    localparam int CTRL_MEMRD    = 5;
    localparam int CTRL_MEMWR    = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [NB_CTRL_DEF-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_load_use_detect.sv
// Combinational load-use hazard detector: an instruction in ID needs a register that
// the load currently in EX has not yet fetched from memory.
module load_use_detect #(
    parameter int NB_REG = 5
) (
    input  logic              i_valid,
    input  logic              i_ex_mem_read,
    input  logic [NB_REG-1:0] i_ex_rd,
    input  logic [NB_REG-1:0] i_rs1,
    input  logic [NB_REG-1:0] i_rs2,
    output logic              o_hz
);

    always_comb begin
        o_hz = i_valid & i_ex_mem_read & (i_ex_rd != '0) &
               ((i_ex_rd == i_rs1) | (i_ex_rd == i_rs2));
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, flush and halt.
// Optional stall/flush event counters are built when CTRL_PIPE_EVENT_CNT_EN is defined.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int NB_CTRL = NB_CTRL_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_CNT  = NB_CNT_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_REG-1:0]  i_rs1,
    input  logic [NB_REG-1:0]  i_rs2,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic               i_flush,
    input  logic               i_halt,
    output logic               o_stall,
    output logic [NB_CTRL-1:0] o_ex_ctrl,
    output logic [NB_REG-1:0]  o_ex_rs1,
    output logic [NB_REG-1:0]  o_ex_rs2,
    output logic [NB_REG-1:0]  o_ex_rd,
    output logic [3:0]         o_mem_ctrl,
    output logic [NB_REG-1:0]  o_mem_rd,
    output logic [1:0]         o_wb_ctrl,
    output logic [NB_REG-1:0]  o_wb_rd,
    output logic [NB_CNT-1:0]  o_stall_cnt,
    output logic [NB_CNT-1:0]  o_flush_cnt
);

    logic [NB_CTRL-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [NB_REG-1:0]  ex_rs1_q, ex_rs1_d;
    logic [NB_REG-1:0]  ex_rs2_q, ex_rs2_d;
    logic [NB_REG-1:0]  ex_rd_q, ex_rd_d;
    logic [3:0]         mem_ctrl_q, mem_ctrl_d;
    logic [NB_REG-1:0]  mem_rd_q, mem_rd_d;
    logic [1:0]         wb_ctrl_q, wb_ctrl_d;
    logic [NB_REG-1:0]  wb_rd_q, wb_rd_d;
    logic               hz;
    logic               stall;

    load_use_detect #(
        .NB_REG (NB_REG)
    ) u_load_use_detect (
        .i_valid       (i_valid),
        .i_ex_mem_read (ex_ctrl_q[CTRL_MEMRD]),
        .i_ex_rd       (ex_rd_q),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .o_hz          (hz)
    );

    // A flush already discards the ID instruction, so stalling it as well would
    // insert a second bubble.
    assign stall = hz & ~i_flush;

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_rd_d   = mem_rd_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_rd_d    = wb_rd_q;
        if (!i_halt) begin
            mem_ctrl_d = {ex_ctrl_q[CTRL_MEM2REG], ex_ctrl_q[CTRL_REGWR],
                          ex_ctrl_q[CTRL_MEMRD], ex_ctrl_q[CTRL_MEMWR]};
            mem_rd_d   = ex_rd_q;
            wb_ctrl_d  = mem_ctrl_q[3:2];
            wb_rd_d    = mem_rd_q;
            if (i_valid && !i_flush && !stall) begin
                ex_ctrl_d             = i_ctrl;
                // Writes to x0 are dropped here so later stages never see them.
                ex_ctrl_d[CTRL_REGWR] = i_ctrl[CTRL_REGWR] & (i_rd != '0);
                ex_rs1_d              = i_rs1;
                ex_rs2_d              = i_rs2;
                ex_rd_d               = i_rd;
            end else begin
                ex_ctrl_d = NB_CTRL'(CTRL_BUBBLE);
                ex_rs1_d  = '0;
                ex_rs2_d  = '0;
                ex_rd_d   = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_ctrl_q  <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_rd_q   <= '0;
            wb_ctrl_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_rd_q   <= mem_rd_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

`ifdef CTRL_PIPE_EVENT_CNT_EN
    logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;
    logic [NB_CNT-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!i_halt) begin
            if (stall) begin
                stall_cnt_d = stall_cnt_q + NB_CNT'(1);
            end
            if (i_flush) begin
                flush_cnt_d = flush_cnt_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

    assign o_stall    = stall;
    assign o_ex_ctrl  = ex_ctrl_q;
    assign o_ex_rs1   = ex_rs1_q;
    assign o_ex_rs2   = ex_rs2_q;
    assign o_ex_rd    = ex_rd_q;
    assign o_mem_ctrl = mem_ctrl_q;
    assign o_mem_rd   = mem_rd_q;
    assign o_wb_ctrl  = wb_ctrl_q;
    assign o_wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: a pipeline-of-instructions model predicts each
// cycle's outputs, a monitor compares them on the falling edge.
module tb_ctrl_pipe_hazard;

    localparam int NB_CTRL = 9;
    localparam int NB_REG  = 5;
    localparam int NB_CNT  = 32;

    logic               clk = 1'b0;
    logic               i_reset, i_valid, i_flush, i_halt;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_REG-1:0]  i_rs1, i_rs2, i_rd;
    logic               o_stall;
    logic [NB_CTRL-1:0] o_ex_ctrl;
    logic [NB_REG-1:0]  o_ex_rs1, o_ex_rs2, o_ex_rd, o_mem_rd, o_wb_rd;
    logic [3:0]         o_mem_ctrl;
    logic [1:0]         o_wb_ctrl;
    logic [NB_CNT-1:0]  o_stall_cnt, o_flush_cnt;

    always #5 clk = ~clk;

    ctrl_pipe_hazard #(.NB_CTRL(NB_CTRL), .NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_ctrl(i_ctrl),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush), .i_halt(i_halt),
        .o_stall(o_stall), .o_ex_ctrl(o_ex_ctrl), .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2),
        .o_ex_rd(o_ex_rd), .o_mem_ctrl(o_mem_ctrl), .o_mem_rd(o_mem_rd),
        .o_wb_ctrl(o_wb_ctrl), .o_wb_rd(o_wb_rd),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    typedef struct packed {
        logic [8:0] ctrl;
        logic [4:0] rs1, rs2, rd;
    } instr_t;

    typedef struct packed {
        logic        stall;
        logic [8:0]  ex_ctrl;
        logic [4:0]  ex_rs1, ex_rs2, ex_rd;
        logic [3:0]  mem_ctrl;
        logic [4:0]  mem_rd;
        logic [1:0]  wb_ctrl;
        logic [4:0]  wb_rd;
        logic [31:0] scnt, fcnt;
    } exp_t;

    exp_t        exp_q[$];
    instr_t      pipe[3];          // 0 = in EX, 1 = in MEM, 2 = in WB
    int unsigned m_scnt, m_fcnt;
    bit          known;
    int          checks, failures, cyc;

    function automatic instr_t nop_instr();
        instr_t b;
        b = '0;
        return b;
    endfunction

    function automatic bit model_stall();
        instr_t e;
        e = pipe[0];
        return i_valid && e.ctrl[5] && e.rd != 0 && (e.rd == i_rs1 || e.rd == i_rs2) && !i_flush;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [8:0] c, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d,
                         input bit fl, input bit ht, input bit rs);
        exp_t e;
        i_valid = v; i_ctrl = c; i_rs1 = s1; i_rs2 = s2; i_rd = d;
        i_flush = fl; i_halt = ht; i_reset = rs;
        if (known) begin
            e.stall    = model_stall();
            e.ex_ctrl  = pipe[0].ctrl;
            e.ex_rs1   = pipe[0].rs1;
            e.ex_rs2   = pipe[0].rs2;
            e.ex_rd    = pipe[0].rd;
            e.mem_ctrl = pipe[1].ctrl[7:4];
            e.mem_rd   = pipe[1].rd;
            e.wb_ctrl  = pipe[2].ctrl[7:6];
            e.wb_rd    = pipe[2].rd;
`ifdef CTRL_PIPE_EVENT_CNT_EN
            e.scnt = m_scnt;
            e.fcnt = m_fcnt;
`else
            e.scnt = 0;
            e.fcnt = 0;
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        bit     st;
        instr_t n;
        st = model_stall();
        @(posedge clk);
        cyc++;
        if (i_reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = nop_instr();
            m_scnt = 0;
            m_fcnt = 0;
            known  = 1;
        end else if (!i_halt) begin
            if (st) m_scnt++;
            if (i_flush) m_fcnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (i_valid && !i_flush && !st) begin
                n.ctrl    = i_ctrl;
                n.ctrl[6] = i_ctrl[6] && (i_rd != 0);
                n.rs1     = i_rs1;
                n.rs2     = i_rs2;
                n.rd      = i_rd;
                pipe[0]   = n;
            end else begin
                pipe[0] = nop_instr();
            end
        end
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_stall",    32'(o_stall),     32'(e.stall));
                chk("sb_ex_ctrl",  32'(o_ex_ctrl),   32'(e.ex_ctrl));
                chk("sb_ex_rs1",   32'(o_ex_rs1),    32'(e.ex_rs1));
                chk("sb_ex_rs2",   32'(o_ex_rs2),    32'(e.ex_rs2));
                chk("sb_ex_rd",    32'(o_ex_rd),     32'(e.ex_rd));
                chk("sb_mem_ctrl", 32'(o_mem_ctrl),  32'(e.mem_ctrl));
                chk("sb_mem_rd",   32'(o_mem_rd),    32'(e.mem_rd));
                chk("sb_wb_ctrl",  32'(o_wb_ctrl),   32'(e.wb_ctrl));
                chk("sb_wb_rd",    32'(o_wb_rd),     32'(e.wb_rd));
                chk("sb_stall_cnt", o_stall_cnt,     e.scnt);
                chk("sb_flush_cnt", o_flush_cnt,     e.fcnt);
            end
        end
    endtask

    task automatic stimulus();
        int unsigned s0, f0;
        bit          hold;
        logic [8:0]  c;
        logic [4:0]  r1, r2, rd;
        bit          v;

        // Reset two cycles while the ID inputs carry junk.
        for (int k = 0; k < 2; k++) begin
            drive(1'($urandom), 9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'b1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_ex_ctrl", 32'(o_ex_ctrl), 0);
        chk("rst_mem_ctrl", 32'(o_mem_ctrl), 0);
        chk("rst_wb_ctrl", 32'(o_wb_ctrl), 0);
        chk("rst_stall", 32'(o_stall), 0);
        tick();

        // ADD flows through all three stages.
        drive(1, 9'h042, 1, 2, 3, 0, 0, 0); tick();
        chk("add_ex_ctrl", 32'(o_ex_ctrl), 32'h042);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("add_mem_ctrl", 32'(o_mem_ctrl), 32'b0100);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("add_wb_ctrl", 32'(o_wb_ctrl), 32'b01);
        chk("add_wb_rd", 32'(o_wb_rd), 3);

        // Load-use: one bubble, then the dependent ADD enters EX.
        drive(1, 9'h1E0, 1, 2, 5, 0, 0, 0); tick();
        drive(1, 9'h042, 5, 6, 7, 0, 0, 0);
        #1 chk("lu_stall", 32'(o_stall), 1);
        tick();
        chk("lu_bubble", 32'(o_ex_ctrl), 0);
        chk("lu_mem_ctrl", 32'(o_mem_ctrl), 32'b1110);
        chk("lu_mem_rd", 32'(o_mem_rd), 5);
        drive(1, 9'h042, 5, 6, 7, 0, 0, 0);
        #1 chk("lu_stall_once", 32'(o_stall), 0);
        tick();
        chk("lu_add_ex", 32'(o_ex_ctrl), 32'h042);
        chk("lu_add_rs1", 32'(o_ex_rs1), 5);

        // Load to x0 never stalls and loses reg_write.
        drive(1, 9'h1E0, 1, 2, 0, 0, 0, 0); tick();
        chk("x0_ex_ctrl", 32'(o_ex_ctrl), 32'h1A0);
        drive(1, 9'h042, 0, 0, 1, 0, 0, 0);
        #1 chk("x0_stall", 32'(o_stall), 0);
        tick();

        // Hazard together with flush.
        drive(1, 9'h1E0, 1, 2, 4, 0, 0, 0); tick();
        s0 = m_scnt; f0 = m_fcnt;
        drive(1, 9'h042, 4, 0, 1, 1, 0, 0);
        #1 chk("fl_stall", 32'(o_stall), 0);
        tick();
        chk("fl_ex_ctrl", 32'(o_ex_ctrl), 0);
        chk("fl_ex_rd", 32'(o_ex_rd), 0);
`ifdef CTRL_PIPE_EVENT_CNT_EN
        chk("fl_stall_cnt", o_stall_cnt, s0);
        chk("fl_flush_cnt", o_flush_cnt, f0 + 1);
`else
        chk("fl_stall_cnt", o_stall_cnt, 0);
        chk("fl_flush_cnt", o_flush_cnt, 0);
`endif

        // Halt for three cycles mid-stream, then resume.
        drive(1, 9'h042, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 9'h0C2, 0, 0, 2, 0, 0, 0); tick();
        drive(1, 9'h062, 0, 0, 3, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 9'h042, 7, 8, 4, 0, 1, 0); tick();
            chk("halt_ex_ctrl", 32'(o_ex_ctrl), 32'h062);
            chk("halt_ex_rd", 32'(o_ex_rd), 3);
            chk("halt_mem_rd", 32'(o_mem_rd), 2);
            chk("halt_wb_rd", 32'(o_wb_rd), 1);
        end
        drive(1, 9'h042, 7, 8, 4, 0, 0, 0); tick();
        chk("resume_ex_rd", 32'(o_ex_rd), 4);
        chk("resume_mem_rd", 32'(o_mem_rd), 3);
        chk("resume_wb_rd", 32'(o_wb_rd), 2);
        chk("resume_wb_ctrl", 32'(o_wb_ctrl), 32'b11);

        // Reset during a stall cycle.
        drive(1, 9'h1E0, 1, 2, 6, 0, 0, 0); tick();
        drive(1, 9'h042, 6, 0, 1, 0, 0, 1);
        #1 chk("rs_stall_before", 32'(o_stall), 1);
        tick();
        chk("rs_ex_ctrl", 32'(o_ex_ctrl), 0);
        chk("rs_mem_ctrl", 32'(o_mem_ctrl), 0);
        chk("rs_wb_ctrl", 32'(o_wb_ctrl), 0);
        chk("rs_stall_cnt", o_stall_cnt, 0);
        chk("rs_flush_cnt", o_flush_cnt, 0);
        drive(1, 9'h042, 6, 0, 1, 0, 0, 0);
        #1 chk("rs_stall_after", 32'(o_stall), 0);
        tick();

        // Randomised traffic with a small register set so hazards are frequent.
        hold = 0; v = 0; c = 0; r1 = 0; r2 = 0; rd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                v  = ($urandom % 8) != 0;
                c  = 9'($urandom);
                if ($urandom % 2 == 0) c[5] = 1'b1;
                r1 = 5'($urandom % 4);
                r2 = 5'($urandom % 4);
                rd = 5'($urandom % 4);
            end
            drive(v, c, r1, r2, rd, ($urandom % 12) == 0, ($urandom % 10) == 0,
                  ($urandom % 150) == 0);
            hold = (model_stall() || i_halt) && !i_reset;
            tick();
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; known = 0;
        m_scnt = 0; m_fcnt = 0;
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        i_reset = 1; i_valid = 0; i_ctrl = 0; i_rs1 = 0; i_rs2 = 0; i_rd = 0;
        i_flush = 0; i_halt = 0;
        fork
            monitor();
            stimulus();
            begin
                #500000;
                failures++;
                $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
            end
        join_any
        disable fork;
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
